// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch front end.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
package fetch_pkg;

  // MIPS opcodes for the absolute jumps that predecode can resolve early.
  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  // One prefetch-queue entry as seen by the 32-bit ISA. The queue itself
  // stores a flat {pc, inst} vector so that ADDR_W/DATA_W stay parametric.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Bits needed to index or count n things (ceil(log2(n)), 0 for n <= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with flush, count and simultaneous push/pop.
// Latency: an entry pushed in cycle N is at the head in cycle N+1 (no same-cycle fall-through).
// Backpressure: push is ignored when full, pop ignored when empty; flush wins over push.
// Ports: clock/reset (async active-low); flush; push_vld/push_dat; pop;
//        head_dat (zero when empty), count, full, empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  parameter int CNT_W = clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push_vld,
  input  logic [W-1:0]     push_dat,
  input  logic             pop,
  output logic [W-1:0]     head_dat,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push_vld && !full && !flush;
  assign do_pop  = pop && !empty;

  // Gate the head so the output bus reads zero whenever nothing is valid.
  assign head_dat = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: sequential requests to variable-latency imem, prefetch queue, redirect squash.
// Latency: 2 cycles request-accept to inst_valid with a next-cycle memory; 1 inst/cycle steady state.
// Backpressure: requests only issue while queue slots cover all in-flight responses; decode stalls via inst_ready.
// Ports: clock, reset (async active-low); imem_req_valid/ready/addr; imem_rsp_valid/data;
//        redirect_valid/pc; inst_valid/ready/data/pc.
// Optional macro FETCH_JUMP_PREDECODE_EN: kept j/jal responses redirect fetch without flushing the queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              DEPTH    = 4,
  parameter int              MAX_OUT  = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int CNT_W   = clog2(DEPTH + 1);
  localparam int SUM_W   = CNT_W + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [CNT_W-1:0]  out_q, out_d;          // requests accepted, response not yet seen
  logic [CNT_W-1:0]  discard_q, discard_d;  // responses still to squash (SQUASH while non-zero)

  logic [CNT_W-1:0]   q_count;
  logic               q_full, q_empty, q_push, q_flush, q_pop;
  logic [ENTRY_W-1:0] q_head;

  logic              req_acc, rsp_keep, rsp_drop;
  logic [CNT_W-1:0]  out_after;
  logic [ADDR_W-1:0] rsp_pc_plus4, redirect_tgt;
  logic              jump_hit;
  logic [ADDR_W-1:0] jump_pc;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Credit rule: every in-flight request already owns a queue slot.
  assign imem_req_valid = reset
                       && (SUM_W'(q_count) + SUM_W'(out_q) < SUM_W'(DEPTH))
                       && (out_q < CNT_W'(MAX_OUT));
  assign imem_req_addr  = fetch_pc_q;

  assign rsp_pc_plus4 = rsp_pc_q + ADDR_W'(4);
  assign redirect_tgt = {redirect_pc[ADDR_W-1:2], 2'b00};

  always_comb begin
    req_acc   = imem_req_valid && imem_req_ready;
    rsp_keep  = imem_rsp_valid && (discard_q == '0);
    rsp_drop  = imem_rsp_valid && (discard_q != '0);
    out_after = out_q + CNT_W'(req_acc) - CNT_W'(imem_rsp_valid);

    jump_hit = 1'b0;
    jump_pc  = '0;
`ifdef FETCH_JUMP_PREDECODE_EN
    if (rsp_keep && (imem_rsp_data[31:26] == OP_J || imem_rsp_data[31:26] == OP_JAL)) begin
      jump_hit = 1'b1;
      jump_pc  = {rsp_pc_plus4[ADDR_W-1:28], imem_rsp_data[25:0], 2'b00};
    end
`endif

    fetch_pc_d = req_acc  ? fetch_pc_q + ADDR_W'(4) : fetch_pc_q;
    rsp_pc_d   = rsp_keep ? rsp_pc_plus4 : rsp_pc_q;
    out_d      = out_after;
    discard_d  = discard_q - CNT_W'(rsp_drop);
    q_push     = rsp_keep;
    q_flush    = 1'b0;

    // Everything still in flight after this cycle belongs to the old stream,
    // including a request accepted right now, so it all has to be squashed.
    // A response arriving this cycle is already accounted for in out_after.
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      rsp_pc_d   = redirect_tgt;
      discard_d  = out_after;
      q_push     = 1'b0;
      q_flush    = 1'b1;
    end else if (jump_hit) begin
      // The jump itself is kept; only younger fetches are dropped.
      fetch_pc_d = jump_pc;
      rsp_pc_d   = jump_pc;
      discard_d  = out_after;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      out_q      <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
    end
  end

  assign q_pop      = inst_valid && inst_ready;
  assign inst_valid = !q_empty;
  assign {inst_pc, inst_data} = q_head;

  fetch_queue #(
    .W     (ENTRY_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_queue (
    .clock    (clock),
    .reset    (reset),
    .flush    (q_flush),
    .push_vld (q_push),
    .push_dat ({rsp_pc_q, imem_rsp_data}),
    .pop      (q_pop),
    .head_dat (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  a_no_overflow: assert property (@(posedge clock) disable iff (!reset) !(q_push && q_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random-latency in-order memory, random redirects, program-order scoreboard.
// Latency: n/a.
// Backpressure: drives random imem_req_ready and inst_ready.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;

  fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Instruction memory contents: a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
`ifdef FETCH_JUMP_PREDECODE_EN
    if (a == 32'h40) return 32'h0800_0100;  // j 0x400
`endif
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- memory model: in-order, random latency >= 1 ----------
  typedef struct { logic [31:0] addr; int rdy; } mreq_t;
  mreq_t mq[$];
  int lat_min = 1, lat_max = 1, ready_pct = 100;
  int acc_cnt = 0;

  initial begin
    logic        acc;
    logic [31:0] a;
    int          c;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clock);
      acc = reset && imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      c   = cyc;
      @(posedge clock);
      #1;
      if (imem_rsp_valid) void'(mq.pop_front());
      if (acc) begin
        mq.push_back('{addr: a, rdy: c + $urandom_range(lat_max, lat_min)});
        acc_cnt++;
      end
      imem_rsp_valid = (mq.size() > 0) && (mq[0].rdy <= cyc);
      imem_rsp_data  = imem_rsp_valid ? mem_word(mq[0].addr) : 32'h0;
      imem_req_ready = ($urandom_range(99, 0) < ready_pct);
    end
  end

  // ---------------- scoreboard ----------------
  // Decode must see program order: consecutive words from the last redirect
  // target (or a predecoded jump target). Redirects are queued with the cycle
  // they are presented in; a handshake in that same cycle still belongs to
  // the old stream.
  typedef struct { int cyc; logic [31:0] pc; } redir_t;
  redir_t rq[$];
  logic [31:0] exp_pc = 32'h0;
  int hs_cnt = 0;
  int first_hs_cyc = -1;

  always @(negedge clock) begin
    logic [31:0] w, nxt;
    if (reset) begin
      if (inst_valid && inst_ready) begin
        w = mem_word(exp_pc);
        chk("inst_pc", inst_pc, exp_pc);
        chk("inst_data", inst_data, w);
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        hs_cnt++;
        nxt = exp_pc + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
        if (w[31:26] == 6'b000010 || w[31:26] == 6'b000011) nxt = {nxt[31:28], w[25:0], 2'b00};
`endif
        exp_pc = nxt;
      end
      while (rq.size() > 0 && rq[0].cyc <= cyc) begin
        exp_pc = rq[0].pc;
        void'(rq.pop_front());
      end
    end
  end

  // Present a redirect for one cycle; returns #1 after the edge that took it.
  task automatic do_redirect(input logic [31:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    rq.push_back('{cyc: cyc, pc: {t[31:2], 2'b00}});
    @(posedge clock);
    #1;
    redirect_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int rel_cyc, a0, h0, n;
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b1;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_inst_data", inst_data, 0);
    chk("rst_inst_pc", inst_pc, 0);

    // Sequential stream from RESET_PC with a next-cycle memory.
    @(posedge clock);
    #1;
    reset   = 1'b1;
    rel_cyc = cyc;
    repeat (14) @(posedge clock);
    #1;
    chk("first_latency", first_hs_cyc - rel_cyc, 2);
    chk("stream_rate", hs_cnt, 12);

    // Decode stall: queue fills to DEPTH and requests stop.
    inst_ready = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    a0 = acc_cnt;
    repeat (10) @(posedge clock);
    #2;
    chk("hold_no_req", acc_cnt - a0, 0);
    chk("hold_req_valid", imem_req_valid, 0);
    chk("hold_inst_valid", inst_valid, 1);
    ready_pct = 0;
    @(posedge clock);
    #1;
    h0 = hs_cnt;
    inst_ready = 1'b1;
    repeat (4) @(posedge clock);
    #2;
    chk("hold_drain_cnt", hs_cnt - h0, 4);
    chk("hold_drain_empty", inst_valid, 0);

    // 3-cycle memory, redirect with requests in flight.
    ready_pct = 100;
    lat_min = 3;
    lat_max = 3;
    repeat (12) @(posedge clock);
    #1;
    do_redirect(32'h100);
    chk("redir_addr", imem_req_addr, 32'h100);
    chk("redir_flush", inst_valid, 0);
    repeat (15) @(posedge clock);

    // Redirect in the same cycle as a response; target has low bits set.
    n = 0;
    do begin
      @(posedge clock);
      #2;
      n++;
    end while (!imem_rsp_valid && n < 50);
    chk("rsp_seen", imem_rsp_valid, 1);
    do_redirect(32'h203);
    chk("rsp_redir_addr", imem_req_addr, 32'h200);
    repeat (15) @(posedge clock);

    // Redirect in the same cycle as a decode handshake.
    n = 0;
    do begin
      @(posedge clock);
      #2;
      n++;
    end while (!inst_valid && n < 50);
    chk("hs_seen", inst_valid, 1);
    h0 = hs_cnt;
    do_redirect(32'h300);
    chk("redir_hs_done", hs_cnt - h0, 1);
    chk("redir_hs_flush", inst_valid, 0);
    repeat (10) @(posedge clock);

    // Random traffic.
    lat_min = 1;
    lat_max = 4;
    ready_pct = 70;
    repeat (3000) begin
      @(posedge clock);
      #1;
      inst_ready = ($urandom_range(3, 0) != 0);
      if ($urandom_range(99, 0) < 4) do_redirect($urandom_range(32'h3FFFF, 32'h1000));
    end

    // Drain with everything open: must keep making progress.
    ready_pct = 100;
    lat_max = 2;
    @(posedge clock);
    #1;
    inst_ready = 1'b1;
    h0 = hs_cnt;
    repeat (60) @(posedge clock);
    #2;
    chk("drain_progress", hs_cnt > h0, 1);
    chk("redir_q_empty", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
